vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_BP, default 48: clocks from HSync rising edge to first active pixel.
REQ-002 Parameter H_ACT, default 640: active pixels per line.
REQ-003 Parameter V_ACT, default 480: active lines per frame.
REQ-004 Parameter LOCK_FRAMES, default 2: consecutive good frames required before lock.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 iHSync  input  1  horizontal sync, active-low, asynchronous to logic.
REQ-008 iVSync  input  1  vertical sync, active-low, asynchronous to logic.
REQ-009 iData  input  3  {R,G,B} pixel channels.
REQ-010 oX  output  10  active pixel column, 0..H_ACT-1.
REQ-011 oY  output  10  active line number, 0..V_ACT-1.
REQ-012 oPixel  output  3  iData captured, aligned with oX/oY.
REQ-013 oValid  output  1  oX/oY/oPixel valid this cycle.
REQ-014 oFrameStart  output  1  one-cycle pulse on first valid pixel of frame (0,0).
REQ-015 oLineLen  output  12  clocks between the last two HSync falling edges, saturating.
REQ-016 oLocked  output  1  timing stable.
REQ-017 oErr  output  1  one-cycle pulse on timing violation.

Function
REQ-018 iHSync, iVSync, iData SHALL pass a 2-flop synchronizer; all edges SHALL be detected on synchronized signals; pixel-path latency input-to-oPixel SHALL be 3 clocks.
REQ-019 FSM states: SEARCH, VSYNC, VBP, LINE, VFP.
REQ-020 SEARCH -> VSYNC on VSync falling edge; no other exit.
REQ-021 VSYNC -> VBP on VSync rising edge; line counter cleared.
REQ-022 VBP -> LINE on HSync falling edge (no HSync pulses occur during vertical blanking).
REQ-023 In LINE, hCnt SHALL clear on HSync rising edge, then increment each clock, saturating at 4095.
REQ-024 oValid SHALL be high exactly when state=LINE, HSync high, H_BP <= hCnt <= H_BP+H_ACT-1; oX = hCnt-H_BP; oY = line counter.
REQ-025 Each HSync falling edge in LINE SHALL increment line counter; when count reaches V_ACT, state -> VFP.
REQ-026 VFP -> VSYNC on VSync falling edge; frame judged good if exactly V_ACT lines and every line's HSync-to-next-HSync length matched the first line's.
REQ-027 VSync falling edge in VBP or LINE (early vsync) SHALL pulse oErr, clear oLocked and good-frame count, enter VSYNC.
REQ-028 HSync falling edge in VFP (extra line) SHALL pulse oErr, clear oLocked, enter SEARCH.
REQ-029 Line length mismatch within a frame SHALL mark frame bad, no oErr.
REQ-030 oLocked SHALL set after LOCK_FRAMES consecutive good frames; bad frame resets count to 0 and clears oLocked.
REQ-031 oLineLen SHALL update on each HSync falling edge in LINE after the first, saturating at 4095.
REQ-032 Simultaneous HSync and VSync falling edges: VSync takes priority.
REQ-033 Outputs SHALL be produced regardless of oLocked.

Reset
REQ-034 On rst: state=SEARCH; oX=0, oY=0, oPixel=0, oValid=0, oFrameStart=0, oLineLen=0, oLocked=0, oErr=0; synchronizers and counters cleared.
REQ-035 rst asserted mid-frame SHALL take effect next clock; receiver resynchronizes only at the next VSync falling edge.

Structure
REQ-036 FSM state encodings and default timing constants (640, 480, 48) SHALL live in shared package vga_pkg, also used by the generator.
REQ-037 Synchronizer plus edge detector SHALL be one sub-module sync_edge (instantiated twice, one per sync), outputs level, rise, fall.

Verification
REQ-038 Drive 3 frames from existing VGA generator (638/478 effective) with params matched -> oLocked rises after 2nd VFP->VSYNC; 480 oFrameStart-to-oFrameStart lines, no oErr.
REQ-039 Pixel pattern iData = x[2:0] -> oPixel equals oX[2:0] on every oValid cycle; oX spans 0..639 per line.
REQ-040 VSync falling at line 200 of a locked stream -> oErr one pulse, oLocked 0 next clock, state VSYNC.
REQ-041 One line 4 clocks longer in frame 2 -> no oErr, good-frame count 0, oLocked stays 0 until two clean frames later.
REQ-042 rst pulsed at pixel (100,50) -> all outputs 0 next clock; oValid stays 0 until after next VSync falling edge and first line's H_BP.
REQ-043 HSync held low 5000 clocks -> oLineLen saturates at 4095, no wrap.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: receiver FSM states and default 640x480 timing.
package vga_pkg;

    typedef enum logic [2:0] {
        ST_SEARCH = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_LINE   = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    localparam int DEF_H_ACT = 640;
    localparam int DEF_V_ACT = 480;
    localparam int DEF_H_BP  = 48;

    localparam int          CNT_W   = 12;
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    // Increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous level plus edge detection on the synchronized copy.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-clock history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from HSync/VSync, measures line
// length and declares lock after a run of consistent frames.
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int H_BP        = DEF_H_BP,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iHSync,
    input  logic        iVSync,
    input  logic [2:0]  iData,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [2:0]  oPixel,
    output logic        oValid,
    output logic        oFrameStart,
    output logic [11:0] oLineLen,
    output logic        oLocked,
    output logic        oErr
);

    localparam logic [11:0] H_FIRST = 12'(H_BP);
    localparam logic [11:0] H_LAST  = 12'(H_BP + H_ACT - 1);
    localparam logic [9:0]  V_LINES = 10'(V_ACT);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;

    sync_edge u_hs_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (iHSync),
        .level_o (hs_lvl),
        .rise_o  (hs_rise),
        .fall_o  (hs_fall)
    );

    sync_edge u_vs_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (iVSync),
        .level_o (vs_lvl),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    state_t      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] len_q, len_d;
    logic [11:0] ref_q, ref_d;
    logic        ref_vld_q, ref_vld_d;
    logic        bad_q, bad_d;
    logic [9:0]  line_q, line_d;
    logic [7:0]  good_q, good_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [11:0] linelen_q, linelen_d;
    logic        hs_hi_q;
    logic [2:0]  data_meta_q, data_sync_q, pix_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_SEARCH;
        else     state_q <= state_d;
    end

    // Next-state, counters, frame judgement and lock bookkeeping.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        bad_d     = bad_q;
        good_d    = good_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        linelen_d = linelen_q;
        hcnt_d    = hs_rise ? '0 : sat_inc12(hcnt_q);
        len_d     = hs_fall ? 12'd1 : sat_inc12(len_q);

        unique case (state_q)
            ST_SEARCH: begin
                if (vs_fall) state_d = ST_VSYNC;
            end
            ST_VSYNC: begin
                if (vs_rise) begin
                    state_d   = ST_VBP;
                    line_d    = '0;
                    ref_vld_d = 1'b0;
                    bad_d     = 1'b0;
                end
            end
            ST_VBP: begin
                if (vs_fall) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                    state_d  = ST_VSYNC;
                end else if (hs_fall && vs_lvl) begin
                    state_d = ST_LINE;
                end
            end
            ST_LINE: begin
                // VSync is checked first so a coincident HSync edge is ignored.
                if (vs_fall) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                    state_d  = ST_VSYNC;
                end else if (hs_fall) begin
                    linelen_d = len_q;
                    if (!ref_vld_q) begin
                        ref_d     = len_q;
                        ref_vld_d = 1'b1;
                    end else if (len_q != ref_q) begin
                        bad_d = 1'b1;
                    end
                    line_d = line_q + 10'd1;
                    if (line_q + 10'd1 == V_LINES) state_d = ST_VFP;
                end
            end
            ST_VFP: begin
                if (vs_fall) begin
                    state_d = ST_VSYNC;
                    if (bad_q) begin
                        good_d   = '0;
                        locked_d = 1'b0;
                    end else begin
                        if (good_q < LOCK_N) good_d = good_q + 8'd1;
                        if (good_q + 8'd1 >= LOCK_N) locked_d = 1'b1;
                    end
                end else if (hs_fall) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                    state_d  = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Datapath registers driven from the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q    <= '0;
            len_q     <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            bad_q     <= 1'b0;
            line_q    <= '0;
            good_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            linelen_q <= '0;
            hs_hi_q   <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            len_q     <= len_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            bad_q     <= bad_d;
            line_q    <= line_d;
            good_q    <= good_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            linelen_q <= linelen_d;
            hs_hi_q   <= hs_lvl;
        end
    end

    // Pixel path: two synchronizer flops plus one stage to line up with hcnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_meta_q <= '0;
            data_sync_q <= '0;
            pix_q       <= '0;
        end else begin
            data_meta_q <= iData;
            data_sync_q <= data_meta_q;
            pix_q       <= data_sync_q;
        end
    end

    // hs_hi_q is the synchronized HSync delayed to the same clock as hcnt_q.
    assign oValid      = (state_q == ST_LINE) && hs_hi_q &&
                         (hcnt_q >= H_FIRST) && (hcnt_q <= H_LAST);
    assign oX          = oValid ? 10'(hcnt_q - H_FIRST) : '0;
    assign oY          = line_q;
    assign oPixel      = pix_q;
    assign oFrameStart = oValid && (hcnt_q == H_FIRST) && (line_q == '0);
    assign oLineLen    = linelen_q;
    assign oLocked     = locked_q;
    assign oErr        = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced timing (4 BP, 16 pixels, 6 lines).
module tb_vga_sync_rx;
    import vga_pkg::*;

    localparam int TB_H_BP  = 4;
    localparam int TB_H_ACT = 16;
    localparam int TB_V_ACT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        iHSync, iVSync;
    logic [2:0]  iData;
    logic [9:0]  oX, oY;
    logic [2:0]  oPixel;
    logic        oValid, oFrameStart, oLocked, oErr;
    logic [11:0] oLineLen;

    int n_vec  = 0;
    int n_miss = 0;

    vga_sync_rx #(
        .H_BP        (TB_H_BP),
        .H_ACT       (TB_H_ACT),
        .V_ACT       (TB_V_ACT),
        .LOCK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iHSync      (iHSync),
        .iVSync      (iVSync),
        .iData       (iData),
        .oX          (oX),
        .oY          (oY),
        .oPixel      (oPixel),
        .oValid      (oValid),
        .oFrameStart (oFrameStart),
        .oLineLen    (oLineLen),
        .oLocked     (oLocked),
        .oErr        (oErr)
    );

    always #5 clk = ~clk;

    // Output monitor statistics, owned by this process only.
    int         n_valid = 0, n_pix_bad = 0, n_seq_bad = 0, n_fs = 0, n_err = 0;
    int         run_cnt = 0, fs_lines = 0;
    logic       seen_fs = 1'b0, prev_valid = 1'b0;
    logic [9:0] prev_x = '0, max_x = '0;

    always @(negedge clk) begin
        if (oErr === 1'b1) n_err <= n_err + 1;
        if (oFrameStart === 1'b1) begin
            n_fs <= n_fs + 1;
            if (seen_fs) fs_lines <= run_cnt;
            seen_fs <= 1'b1;
        end
        if (oValid === 1'b1) begin
            n_valid <= n_valid + 1;
            if (oPixel !== oX[2:0]) n_pix_bad <= n_pix_bad + 1;
            if (oX !== (prev_valid ? prev_x + 10'd1 : 10'd0)) n_seq_bad <= n_seq_bad + 1;
            if (oX > max_x) max_x <= oX;
        end
        if (oFrameStart === 1'b1) run_cnt <= 1;
        else if (oValid === 1'b1 && !prev_valid) run_cnt <= run_cnt + 1;
        prev_valid <= (oValid === 1'b1);
        prev_x     <= oX;
    end

    task automatic cyc(input logic hs, input logic vs, input logic [2:0] d);
        iHSync = hs;
        iVSync = vs;
        iData  = d;
        @(posedge clk);
        #1;
    endtask

    // One line: 3 clocks HSync low, H_BP back porch, active pixels carrying x[2:0], front porch.
    task automatic drive_line(input int extra);
        repeat (3) cyc(1'b0, 1'b1, 3'd0);
        repeat (TB_H_BP) cyc(1'b1, 1'b1, 3'd0);
        for (int x = 0; x < TB_H_ACT; x++) cyc(1'b1, 1'b1, x[2:0]);
        repeat (3 + extra) cyc(1'b1, 1'b1, 3'd0);
    endtask

    task automatic drive_vhead();
        repeat (5) cyc(1'b1, 1'b0, 3'd0);
        repeat (6) cyc(1'b1, 1'b1, 3'd0);
    endtask

    // Full frame; the extra trailing HSync pulse closes the last active line.
    task automatic drive_frame(input int long_line);
        drive_vhead();
        for (int l = 0; l < TB_V_ACT; l++) drive_line((l == long_line) ? 4 : 0);
        drive_line(0);
        repeat (4) cyc(1'b1, 1'b1, 3'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc(1'b1, 1'b1, 3'd0);
        rst = 1'b0;
        repeat (4) cyc(1'b1, 1'b1, 3'd0);
        n_vec++;
        if ({oX, oY, oPixel, oValid, oFrameStart, oLineLen, oLocked, oErr} !== 39'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {oX, oY, oPixel, oValid, oFrameStart, oLineLen, oLocked, oErr});
        end
        n_vec++;
        if (dut.state_q !== ST_SEARCH) begin
            n_miss++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_SEARCH);
        end
    endtask

    task automatic test_frames();
        int v0, f0, e0;
        v0 = n_valid; f0 = n_fs; e0 = n_err;
        drive_frame(-1);
        drive_frame(-1);
        n_vec++;
        if (oLocked !== 1'b0) begin
            n_miss++; $display("FAIL frames_unlocked_after_f2: oLocked=%0b expected 0", oLocked);
        end
        drive_frame(-1);
        n_vec++;
        if (oLocked !== 1'b1) begin
            n_miss++; $display("FAIL frames_locked_after_f3: oLocked=%0b expected 1", oLocked);
        end
        n_vec++;
        if (n_fs - f0 !== 3) begin
            n_miss++; $display("FAIL frames_fs_count: got %0d expected 3", n_fs - f0);
        end
        n_vec++;
        if (n_valid - v0 !== 3 * TB_V_ACT * TB_H_ACT) begin
            n_miss++; $display("FAIL frames_valid_count: got %0d expected %0d", n_valid - v0, 3 * TB_V_ACT * TB_H_ACT);
        end
        n_vec++;
        if (fs_lines !== TB_V_ACT) begin
            n_miss++; $display("FAIL frames_lines_per_frame: got %0d expected %0d", fs_lines, TB_V_ACT);
        end
        n_vec++;
        if (n_pix_bad !== 0) begin
            n_miss++; $display("FAIL frames_pixel_match: got %0d bad expected 0", n_pix_bad);
        end
        n_vec++;
        if (n_seq_bad !== 0) begin
            n_miss++; $display("FAIL frames_x_sequence: got %0d bad expected 0", n_seq_bad);
        end
        n_vec++;
        if (max_x !== 10'(TB_H_ACT - 1)) begin
            n_miss++; $display("FAIL frames_max_x: got %0d expected %0d", max_x, TB_H_ACT - 1);
        end
        n_vec++;
        if (n_err - e0 !== 0) begin
            n_miss++; $display("FAIL frames_no_err: got %0d expected 0", n_err - e0);
        end
        n_vec++;
        if (oLineLen !== 12'd26) begin
            n_miss++; $display("FAIL frames_linelen: got %0d expected 26", oLineLen);
        end
    endtask

    task automatic test_early_vsync();
        int e0;
        e0 = n_err;
        drive_vhead();
        for (int l = 0; l < 3; l++) drive_line(0);
        iVSync = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({oErr, oLocked} !== 2'b01) begin
            n_miss++; $display("FAIL early_vs_before: err/locked=%b expected 01", {oErr, oLocked});
        end
        @(negedge clk);
        n_vec++;
        if ({oErr, oLocked} !== 2'b10) begin
            n_miss++; $display("FAIL early_vs_pulse: err/locked=%b expected 10", {oErr, oLocked});
        end
        n_vec++;
        if (dut.state_q !== ST_VSYNC) begin
            n_miss++; $display("FAIL early_vs_state: got %0d expected %0d", dut.state_q, ST_VSYNC);
        end
        @(negedge clk);
        n_vec++;
        if (oErr !== 1'b0) begin
            n_miss++; $display("FAIL early_vs_single_pulse: oErr=%0b expected 0", oErr);
        end
        @(posedge clk); #1;
        repeat (2) cyc(1'b1, 1'b0, 3'd0);
        repeat (6) cyc(1'b1, 1'b1, 3'd0);
        for (int l = 0; l <= TB_V_ACT; l++) drive_line(0);
        repeat (4) cyc(1'b1, 1'b1, 3'd0);
        n_vec++;
        if (n_err - e0 !== 1) begin
            n_miss++; $display("FAIL early_vs_err_count: got %0d expected 1", n_err - e0);
        end
    endtask

    task automatic test_extra_line();
        int e0;
        e0 = n_err;
        drive_line(0);
        n_vec++;
        if (n_err - e0 !== 1) begin
            n_miss++; $display("FAIL extra_line_err: got %0d expected 1", n_err - e0);
        end
        n_vec++;
        if (dut.state_q !== ST_SEARCH) begin
            n_miss++; $display("FAIL extra_line_state: got %0d expected %0d", dut.state_q, ST_SEARCH);
        end
    endtask

    task automatic test_line_mismatch();
        int e0;
        e0 = n_err;
        drive_frame(-1);
        drive_frame(2);
        drive_frame(-1);
        n_vec++;
        if (dut.good_q !== 8'd0) begin
            n_miss++; $display("FAIL mismatch_good_cleared: got %0d expected 0", dut.good_q);
        end
        drive_frame(-1);
        n_vec++;
        if (oLocked !== 1'b0) begin
            n_miss++; $display("FAIL mismatch_still_unlocked: oLocked=%0b expected 0", oLocked);
        end
        drive_frame(-1);
        n_vec++;
        if (oLocked !== 1'b1) begin
            n_miss++; $display("FAIL mismatch_relock: oLocked=%0b expected 1", oLocked);
        end
        n_vec++;
        if (n_err - e0 !== 0) begin
            n_miss++; $display("FAIL mismatch_no_err: got %0d expected 0", n_err - e0);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        drive_vhead();
        for (int l = 0; l < 3; l++) drive_line(0);
        repeat (3) cyc(1'b0, 1'b1, 3'd0);
        repeat (TB_H_BP) cyc(1'b1, 1'b1, 3'd0);
        for (int x = 0; x < 12; x++) cyc(1'b1, 1'b1, x[2:0]);
        n_vec++;
        if ({oValid, oX, oY, oPixel, oLocked} !== {1'b1, 10'd9, 10'd3, 3'd1, 1'b1}) begin
            n_miss++;
            $display("FAIL midframe_before_rst: valid=%0b x=%0d y=%0d pix=%0d lock=%0b expected 1 9 3 1 1",
                     oValid, oX, oY, oPixel, oLocked);
        end
        rst = 1'b1;
        cyc(1'b1, 1'b1, 3'd4);
        rst = 1'b0;
        n_vec++;
        if ({oX, oY, oPixel, oValid, oFrameStart, oLineLen, oLocked, oErr} !== 39'd0) begin
            n_miss++;
            $display("FAIL midframe_rst_outputs: got %h expected 0",
                     {oX, oY, oPixel, oValid, oFrameStart, oLineLen, oLocked, oErr});
        end
        v0 = n_valid;
        for (int x = 13; x < TB_H_ACT; x++) cyc(1'b1, 1'b1, x[2:0]);
        repeat (3) cyc(1'b1, 1'b1, 3'd0);
        for (int l = 4; l <= TB_V_ACT; l++) drive_line(0);
        repeat (4) cyc(1'b1, 1'b1, 3'd0);
        n_vec++;
        if (n_valid - v0 !== 0) begin
            n_miss++; $display("FAIL midframe_no_valid_until_vsync: got %0d expected 0", n_valid - v0);
        end
        v0 = n_valid; f0 = n_fs;
        drive_frame(-1);
        n_vec++;
        if (n_valid - v0 !== TB_V_ACT * TB_H_ACT) begin
            n_miss++; $display("FAIL midframe_resync_valid: got %0d expected %0d", n_valid - v0, TB_V_ACT * TB_H_ACT);
        end
        n_vec++;
        if (n_fs - f0 !== 1) begin
            n_miss++; $display("FAIL midframe_resync_fs: got %0d expected 1", n_fs - f0);
        end
    endtask

    task automatic test_linelen_sat();
        int e0;
        e0 = n_err;
        drive_vhead();
        drive_line(0);
        repeat (5000) cyc(1'b0, 1'b1, 3'd0);
        n_vec++;
        if (oLineLen !== 12'd26) begin
            n_miss++; $display("FAIL sat_first_line_len: got %0d expected 26", oLineLen);
        end
        repeat (TB_H_BP + TB_H_ACT + 3) cyc(1'b1, 1'b1, 3'd0);
        drive_line(0);
        n_vec++;
        if (oLineLen !== 12'd4095) begin
            n_miss++; $display("FAIL sat_long_line_len: got %0d expected 4095", oLineLen);
        end
        drive_line(0);
        n_vec++;
        if (oLineLen !== 12'd26) begin
            n_miss++; $display("FAIL sat_recover_len: got %0d expected 26", oLineLen);
        end
        for (int l = 4; l <= TB_V_ACT; l++) drive_line(0);
        repeat (4) cyc(1'b1, 1'b1, 3'd0);
        n_vec++;
        if (n_err - e0 !== 0) begin
            n_miss++; $display("FAIL sat_no_err: got %0d expected 0", n_err - e0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        iHSync = 1'b1;
        iVSync = 1'b1;
        iData  = 3'd0;
        test_reset();
        test_frames();
        test_early_vsync();
        test_extra_line();
        test_line_mismatch();
        test_reset_midframe();
        test_linelen_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
